// File: rtl/ex_wb_pipe_reg_pkg.sv
// Shared widths, flag indices, payload struct and skid-buffer state for the EX/WB pipeline register.
package ex_wb_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_OPC_W   = 5;
    localparam int DEF_RD_W    = 3;
    localparam int DEF_MADDR_W = 4;
    localparam int DEF_IADDR_W = 6;
    localparam int DEF_NFLAGS  = 4;

    localparam int ZF  = 0;
    localparam int CF  = 1;
    localparam int ACF = 2;
    localparam int PF  = 3;

    typedef struct packed {
        logic [DEF_OPC_W-1:0]   opcode;
        logic                   am;
        logic [DEF_RD_W-1:0]    rd;
        logic [DEF_MADDR_W-1:0] mem_addr;
        logic [DEF_IADDR_W-1:0] instr_mem_addr;
        logic [DEF_DATA_W-1:0]  result;
        logic [DEF_NFLAGS-1:0]  flags;
    } ex_wb_payload_t;

    localparam int PAYLOAD_W = $bits(ex_wb_payload_t);

    // Encoded so that the state value is the number of held entries.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_MAIN  = 2'd1,
        OCC_BOTH  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/ex_wb_pipe_reg_if.sv
// EX->WB handshake bundle. Valid/ready: a beat transfers on a rising edge where valid and ready are both 1;
// the sender holds payload stable while valid=1 and ready=0. flush kills held entries on the edge it is high.
interface ex_wb_pipe_reg_if
    import ex_wb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OPC_W   = DEF_OPC_W,
    parameter int RD_W    = DEF_RD_W,
    parameter int MADDR_W = DEF_MADDR_W,
    parameter int IADDR_W = DEF_IADDR_W,
    parameter int NFLAGS  = DEF_NFLAGS
) ();

    logic [OPC_W-1:0]   in_opcode;
    logic               in_am;
    logic [RD_W-1:0]    in_rd;
    logic [MADDR_W-1:0] in_mem_addr;
    logic [IADDR_W-1:0] in_instr_mem_addr;
    logic [DATA_W-1:0]  in_result;
    logic [NFLAGS-1:0]  in_flags;
    logic               in_valid;
    logic               in_ready;

    logic [OPC_W-1:0]   out_opcode;
    logic               out_am;
    logic [RD_W-1:0]    out_rd;
    logic [MADDR_W-1:0] out_mem_addr;
    logic [IADDR_W-1:0] out_instr_mem_addr;
    logic [DATA_W-1:0]  out_result;
    logic [NFLAGS-1:0]  out_flags;
    logic               out_valid;
    logic               out_ready;

    logic               flush;
    logic [1:0]         occupancy;
    skid_state_e        dbg_state;

    modport master (
        output in_opcode, in_am, in_rd, in_mem_addr, in_instr_mem_addr, in_result, in_flags,
        output in_valid, out_ready, flush,
        input  in_ready, out_valid, occupancy, dbg_state,
        input  out_opcode, out_am, out_rd, out_mem_addr, out_instr_mem_addr, out_result, out_flags
    );

    modport slave (
        input  in_opcode, in_am, in_rd, in_mem_addr, in_instr_mem_addr, in_result, in_flags,
        input  in_valid, out_ready, flush,
        output in_ready, out_valid, occupancy, dbg_state,
        output out_opcode, out_am, out_rd, out_mem_addr, out_instr_mem_addr, out_result, out_flags
    );

endinterface

// File: rtl/ex_wb_pipe_reg_skid_buffer.sv
// Generic two-entry skid buffer: registered in_ready, one-cycle latency, no input-to-output combinational path.
module skid_buffer
    import ex_wb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [W-1:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [W-1:0] out_data,
    input  logic        out_ready,
    output logic [1:0]  occupancy,
    output skid_state_e state
);

    skid_state_e   state_q, state_d;
    logic [W-1:0]  main_q, main_d;
    logic [W-1:0]  skid_q, skid_d;
    logic          in_ready_q, in_ready_d;
    logic          in_xfer, out_xfer;

    assign in_xfer   = in_valid & in_ready_q;
    assign out_xfer  = out_valid & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign state     = state_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Data registers keep their contents so out_* holds its last value.
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_data;
                        state_d = OCC_MAIN;
                    end
                end
                OCC_MAIN: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        skid_d  = in_data;
                        state_d = OCC_BOTH;
                    end else if (out_xfer) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_BOTH: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = OCC_MAIN;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
        in_ready_d = (state_d != OCC_BOTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OCC_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/ex_wb_pipe_reg.sv
// EX->WB pipeline register: packs the EX payload into the shared struct and holds it in a skid buffer.
module ex_wb_pipe_reg
    import ex_wb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OPC_W   = DEF_OPC_W,
    parameter int RD_W    = DEF_RD_W,
    parameter int MADDR_W = DEF_MADDR_W,
    parameter int IADDR_W = DEF_IADDR_W,
    parameter int NFLAGS  = DEF_NFLAGS
) (
    input  logic            clk,
    input  logic            rst,
    ex_wb_pipe_reg_if.slave bus
);

    localparam int W = OPC_W + 1 + RD_W + MADDR_W + IADDR_W + DATA_W + NFLAGS;

    // The payload struct is fixed by the package widths; overriding parameters must keep them equal.
    generate
        if (W != PAYLOAD_W) begin : g_width_check
            $error("ex_wb_pipe_reg: parameter widths do not match ex_wb_payload_t");
        end
    endgenerate

    ex_wb_payload_t in_pl;
    ex_wb_payload_t out_pl;

    always_comb begin
        in_pl                = '0;
        in_pl.opcode         = bus.in_opcode;
        in_pl.am             = bus.in_am;
        in_pl.rd             = bus.in_rd;
        in_pl.mem_addr       = bus.in_mem_addr;
        in_pl.instr_mem_addr = bus.in_instr_mem_addr;
        in_pl.result         = bus.in_result;
        in_pl.flags          = bus.in_flags;
    end

    skid_buffer #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_data   (in_pl),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .out_data  (out_pl),
        .out_ready (bus.out_ready),
        .occupancy (bus.occupancy),
        .state     (bus.dbg_state)
    );

    assign bus.out_opcode         = out_pl.opcode;
    assign bus.out_am             = out_pl.am;
    assign bus.out_rd             = out_pl.rd;
    assign bus.out_mem_addr       = out_pl.mem_addr;
    assign bus.out_instr_mem_addr = out_pl.instr_mem_addr;
    assign bus.out_result         = out_pl.result;
    assign bus.out_flags          = out_pl.flags;

endmodule

// File: tb/tb_ex_wb_pipe_reg.sv
// Randomized scoreboard bench for ex_wb_pipe_reg against a queue model of the held entries.
module tb_ex_wb_pipe_reg;
    import ex_wb_pkg::*;

    localparam int PW = PAYLOAD_W;

    logic clk;
    logic rst;

    ex_wb_pipe_reg_if bus ();

    ex_wb_pipe_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] hold_pl;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] rand_pl();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] mk_pl(input logic [15:0] result, input logic [2:0] rd);
        ex_wb_payload_t p;
        p        = rand_pl();
        p.result = result;
        p.rd     = rd;
        return p;
    endfunction

    function automatic logic [PW-1:0] out_pl();
        ex_wb_payload_t p;
        p.opcode         = bus.out_opcode;
        p.am             = bus.out_am;
        p.rd             = bus.out_rd;
        p.mem_addr       = bus.out_mem_addr;
        p.instr_mem_addr = bus.out_instr_mem_addr;
        p.result         = bus.out_result;
        p.flags          = bus.out_flags;
        return p;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [PW-1:0] pl, input logic ordy, input logic fl);
        ex_wb_payload_t p;
        p                     = pl;
        bus.in_valid          = v;
        bus.in_opcode         = p.opcode;
        bus.in_am             = p.am;
        bus.in_rd             = p.rd;
        bus.in_mem_addr       = p.mem_addr;
        bus.in_instr_mem_addr = p.instr_mem_addr;
        bus.in_result         = p.result;
        bus.in_flags          = p.flags;
        bus.out_ready         = ordy;
        bus.flush             = fl;
    endtask

    // Drive one cycle's inputs, then return at posedge+1.
    task automatic cycle(input logic v, input logic [PW-1:0] pl, input logic ordy, input logic fl);
        drive(v, pl, ordy, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, rand_pl(), ordy, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(1'b0));
        chk({tag, "_occupancy"}, 64'(bus.occupancy), 64'(2'd0));
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'(1'b1));
        chk({tag, "_payload"},   64'(out_pl()),      64'(0));
    endtask

    // ---------------- scoreboard monitor ----------------
    // Samples at the falling edge: inputs and outputs are both stable for the next rising edge.
    always @(negedge clk) begin
        int n;
        if (rst) begin
            n = exp_q.size();
            chk("occupancy", 64'(bus.occupancy), 64'(n));
            chk("out_valid", 64'(bus.out_valid), 64'(n != 0));
            chk("in_ready",  64'(bus.in_ready),  64'(n < 2));
            if (n > 0) begin
                chk("out_payload", 64'(out_pl()), 64'(exp_q[0]));
                hold_pl = exp_q[0];
            end else begin
                chk("held_payload", 64'(out_pl()), 64'(hold_pl));
            end
            if (n > 0 && bus.out_ready) exp_q.delete(0);
            if (bus.flush) exp_q.delete();
            else if (bus.in_valid && n < 2) exp_q.push_back(out_pl_in());
        end
    end

    function automatic logic [PW-1:0] out_pl_in();
        ex_wb_payload_t p;
        p.opcode         = bus.in_opcode;
        p.am             = bus.in_am;
        p.rd             = bus.in_rd;
        p.mem_addr       = bus.in_mem_addr;
        p.instr_mem_addr = bus.in_instr_mem_addr;
        p.result         = bus.in_result;
        p.flags          = bus.in_flags;
        return p;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [PW-1:0] a, b, pl;
        hold_pl = '0;
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1 chk_reset_state("reset");
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // single payload, one-cycle latency
        cycle(1'b1, mk_pl(16'h00A5, 3'd2), 1'b1, 1'b0);
        chk("lat_out_valid", 64'(bus.out_valid), 64'(1'b1));
        chk("lat_result",    64'(bus.out_result), 64'(16'h00A5));
        chk("lat_rd",        64'(bus.out_rd), 64'(3'd2));
        chk("lat_occupancy", 64'(bus.occupancy), 64'(2'd1));
        idle(1'b1);

        // fill main + skid, then drain in order
        a = mk_pl(16'h1111, 3'd1);
        b = mk_pl(16'h2222, 3'd3);
        cycle(1'b1, a, 1'b0, 1'b0);
        cycle(1'b1, b, 1'b0, 1'b0);
        chk("full_occupancy", 64'(bus.occupancy), 64'(2'd2));
        chk("full_in_ready",  64'(bus.in_ready), 64'(1'b0));
        chk("full_head",      64'(bus.out_result), 64'(16'h1111));
        idle(1'b1);
        chk("drain1_result",   64'(bus.out_result), 64'(16'h2222));
        chk("drain1_in_ready", 64'(bus.in_ready), 64'(1'b1));
        idle(1'b1);
        chk("drain2_out_valid", 64'(bus.out_valid), 64'(1'b0));

        // streaming
        for (int i = 0; i < 8; i++) begin
            chk("stream_in_ready", 64'(bus.in_ready), 64'(1'b1));
            pl = mk_pl(16'(16'h3000 + i), 3'(i));
            cycle(1'b1, pl, 1'b1, 1'b0);
        end
        chk("stream_last", 64'(bus.out_result), 64'(16'h3007));
        idle(1'b1);

        // flush while full with a simultaneous input
        cycle(1'b1, mk_pl(16'h4444, 3'd4), 1'b0, 1'b0);
        cycle(1'b1, mk_pl(16'h5555, 3'd5), 1'b0, 1'b0);
        cycle(1'b1, mk_pl(16'hDEAD, 3'd6), 1'b0, 1'b1);
        chk("flush_out_valid", 64'(bus.out_valid), 64'(1'b0));
        chk("flush_occupancy", 64'(bus.occupancy), 64'(2'd0));
        chk("flush_in_ready",  64'(bus.in_ready), 64'(1'b1));
        chk("flush_held",      64'(bus.out_result), 64'(16'h4444));
        idle(1'b1);
        idle(1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), rand_pl(), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 24) == 0));
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("rand_drained", 64'(bus.occupancy), 64'(2'd0));

        // asynchronous reset mid-cycle while full
        cycle(1'b1, mk_pl(16'h6666, 3'd1), 1'b0, 1'b0);
        cycle(1'b1, mk_pl(16'h7777, 3'd2), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1 chk_reset_state("async_reset");
        exp_q.delete();
        hold_pl = '0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, mk_pl(16'h8888, 3'd7), 1'b1, 1'b0);
        chk("post_reset_valid",  64'(bus.out_valid), 64'(1'b1));
        chk("post_reset_result", 64'(bus.out_result), 64'(16'h8888));

        for (int i = 0; i < 100; i++) begin
            cycle(($urandom_range(0, 1) != 0), rand_pl(), ($urandom_range(0, 3) != 0), 1'b0);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("final_drained", 64'(bus.occupancy), 64'(2'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_wb_pipe_reg.md
EX_WB_PIPE_REG -- requirements
Module: ex_wb_pipe_reg

Interface
REQ-001 Parameter DATA_W, 16, width of the ALU result field.
REQ-002 Parameter OPC_W, 5, opcode width.
REQ-003 Parameter RD_W, 3, destination-register index width.
REQ-004 Parameter MADDR_W, 4, data-memory address width.
REQ-005 Parameter IADDR_W, 6, instruction-memory address width.
REQ-006 Parameter NFLAGS, 4, flag count; bit 0 zero, bit 1 carry, bit 2 aux-carry, bit 3 parity.
REQ-007 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-008 Port rst  in  1  asynchronous, active-low reset.
REQ-009 Ports in_opcode, in_am, in_rd, in_mem_addr, in_instr_mem_addr, in_result, in_flags  in  OPC_W/1/RD_W/MADDR_W/IADDR_W/DATA_W/NFLAGS  EX-stage payload.
REQ-010 Port in_valid  in  1  EX payload valid this cycle.
REQ-011 Port in_ready  out  1  stage can accept the EX payload this cycle.
REQ-012 Ports out_opcode, out_am, out_rd, out_mem_addr, out_instr_mem_addr, out_result, out_flags  out  same widths  WB-stage payload.
REQ-013 Port out_valid  out  1  WB payload valid.
REQ-014 Port out_ready  in  1  WB consumes the payload this cycle.
REQ-015 Port flush  in  1  synchronous kill of all held entries (branch/jump redirect).
REQ-016 Port occupancy  out  2  held entries, 0..2.

Function
REQ-017 The block SHALL be an edge-triggered two-entry skid buffer (main + skid) replacing the level-sensitive latch; no combinational path from in_* to out_*.
REQ-018 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer on a rising edge with out_valid=1 and out_ready=1.
REQ-019 Latency SHALL be exactly one cycle: a payload accepted into an empty block appears on out_* with out_valid=1 in the next cycle.
REQ-020 in_ready SHALL be registered and equal 1 exactly when the skid entry is empty; it SHALL NOT depend combinationally on out_ready.
REQ-021 When main is full and out_ready=0 during an input transfer, the payload SHALL go to skid; in_ready SHALL drop next cycle.
REQ-022 When the skid is full, an output transfer SHALL move skid into main in the same edge; in_ready SHALL return to 1 next cycle.
REQ-023 Simultaneous input and output transfers with one entry held SHALL replace main with the new payload; occupancy stays 1.
REQ-024 Order SHALL be preserved; no payload SHALL be duplicated or dropped except by flush.
REQ-025 flush=1 SHALL clear both entries on that edge (occupancy 0, out_valid 0, in_ready 1 next cycle) and SHALL take precedence over any simultaneous input transfer, which is discarded.
REQ-026 out_* payload SHALL hold its last value while out_valid=0 (no data clearing on drain or flush).
REQ-027 occupancy SHALL equal out_valid + (skid valid), never exceeding 2.

Reset
REQ-028 While rst=0, asynchronously: out_valid=0, skid empty, occupancy=0, in_ready=1, all out_* payload and skid payload = 0.
REQ-029 Reset mid-operation SHALL discard all held entries; first input accepted after deassertion appears one cycle later.

Structure
REQ-030 Package ex_wb_pkg SHALL hold the width defaults, flag index constants (ZF=0, CF=1, ACF=2, PF=3) and the packed EX/WB payload struct type.
REQ-031 A generic sub-module skid_buffer (parameter W, valid/ready both sides, flush) SHALL hold the logic; the top packs/unpacks the payload struct.

Verification
REQ-032 Reset, then in_valid with result=16'h00A5, rd=3'd2, out_ready=1 -> next cycle out_valid=1, out_result=16'h00A5, occupancy=1.
REQ-033 out_ready=0; push A=16'h1111 then B=16'h2222 -> occupancy=2, in_ready=0; raise out_ready -> A then B on consecutive cycles, in_ready=1 after A leaves.
REQ-034 Streaming 8 payloads with in_valid=out_ready=1 -> 8 outputs in order, one per cycle, in_ready constant 1.
REQ-035 occupancy=2, flush=1 with in_valid=1 (result=16'hDEAD) -> next cycle out_valid=0, occupancy=0, 16'hDEAD never appears.
REQ-036 rst pulsed low mid-edge with occupancy=2 -> outputs cleared immediately without a clock edge, in_ready=1.
